simd_sequencer: RTL and testbench
=================================

# simd_sequencer

Program sequencer for the SIMD datapath. It takes a start request from the host and fetches instructions from the synchronous instruction memory. It issues one instruction per two-cycle issue slot, which matches the datapath's half-rate pipeline. It inserts NOP bubbles on read-after-write hazards against in-flight writes, and on a HALT opcode it drains the pipeline and signals done.

## Interface
Parameters:
- INS_ADDR_WIDTH, 8, instruction memory address width (pc width)
- ADDR_WIDTH, 10, data BRAM address width
- OPCODE_WIDTH, 4, opcode field width
- HALT_OPCODE, 4'hF, opcode that ends the program
- DRAIN_SLOTS, 3, issue slots waited after HALT before done

Instruction word layout (INS_WIDTH = OPCODE_WIDTH+3*ADDR_WIDTH), MSB first: {opcode, r_addr, a_addr, b_addr}. Opcode 0 is NOP; every other non-HALT opcode writes r_addr.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous, active-low reset
- start  in  1  begin execution (sampled in IDLE only)
- start_pc  in  INS_ADDR_WIDTH  first instruction address
- stall  in  1  freeze all sequencer state
- imem_addr  out  INS_ADDR_WIDTH  instruction memory read address
- imem_dout  in  INS_WIDTH  instruction memory data, valid 1 cycle after address
- instruction  out  INS_WIDTH  instruction to datapath (all-zero = NOP)
- ins_valid  out  1  instruction carries a real (non-bubble) op
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at program end

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE→RUN when start=1. This loads pc=start_pc, phase=0, and clears the scoreboard.
  - RUN→DRAIN on HALT fetch.
  - DRAIN→IDLE after DRAIN_SLOTS slots; done pulses on that transition cycle.
- Phase bit toggles every non-stalled cycle in RUN/DRAIN. A slot is a phase 0 cycle followed by a phase 1 cycle.
- RUN, phase 0: imem_addr=pc.
- RUN, phase 1: imem_dout is valid; decode the opcode, a_addr and b_addr.
  - HALT: do not issue; output a bubble; go to DRAIN.
  - Hazard: a_addr or b_addr equals a valid scoreboard entry's r_addr. Output a bubble; pc is unchanged, so the same instruction is refetched next slot.
  - Otherwise: register instruction=imem_dout and ins_valid=1 (NOP issues with ins_valid=1 but does not write). pc←pc+1, wrapping from 2^INS_ADDR_WIDTH-1 to 0.
- Scoreboard: 2 entries {valid, r_addr}, shifted once per slot at phase 1. Entry 0 receives the issued instruction's write info; a bubble, NOP or HALT shifts in valid=0. Both entries are compared; the oldest entry drops out.
- DRAIN: output bubbles, shift the scoreboard, count slots 0..DRAIN_SLOTS-1.
- stall=1: phase, pc, state, scoreboard, drain count and output registers all hold; done never pulses while stalled.
- start while busy is ignored.

## Timing
- Reset values: imem_addr=0, instruction=0, ins_valid=0, busy=0, done=0; state IDLE; phase 0; scoreboard invalid.
- Reset asserted mid-program aborts immediately with no done pulse.
- instruction/ins_valid update on the clock edge ending phase 1 and hold for 2 cycles (one full slot).
- start at edge N:
  - busy=1 from N+1.
  - First imem_addr=start_pc during N+1.
  - First instruction visible from N+3.
- Throughput: 1 instruction per slot when hazard-free. A dependent back-to-back pair costs 2 bubble slots; dependence at distance 2 costs 1 bubble slot.
- HALT fetched in slot k: done pulses at the end of slot k+DRAIN_SLOTS; busy falls the cycle after.
- imem_addr holds its last value in IDLE.

## Test plan
- Straight-line program: start_pc=0x10, 4 independent writes then HALT. Expect:
  - 4 issues on consecutive slots, pc 0x10..0x13;
  - HALT at 0x14;
  - done exactly 3 slots after the HALT slot;
  - busy drops the following cycle.
- RAW hazard: instr0 writes r=5; instr1 reads a=5. Expect 2 bubble slots (ins_valid=0, instruction=0), then instr1 issues. With one independent instr between them, expect 1 bubble.
- No false hazard: instr0 writes r=5; instr1 reads a=6, b=7; a NOP with r_addr=5 followed by a read of 5. Expect zero bubbles in both cases.
- Stall: assert stall for 5 cycles mid-slot. All outputs freeze; after release the issue sequence and the done cycle are delayed by exactly 5 cycles.
- Wrap and start rules:
  - start_pc=0xFF with an instruction at 0xFF and HALT at 0x00: pc wraps and the program halts normally.
  - start pulsed while busy is ignored.
- Reset mid-RUN: deassert rstn asynchronously. All outputs go to 0 with no done; a new start afterwards runs cleanly from start_pc.

Source files
------------

// File: rtl/simd_sequencer.sv
// Program sequencer for the half-rate SIMD datapath: fetches from synchronous
// instruction memory, issues one instruction per two-cycle slot, bubbles on RAW hazards.
module simd_sequencer #(
    parameter int INS_ADDR_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int OPCODE_WIDTH = 4,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 4'hF,
    parameter int DRAIN_SLOTS = 3,
    localparam int INS_WIDTH = OPCODE_WIDTH + 3 * ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [INS_ADDR_WIDTH-1:0] start_pc,
    input  logic                      stall,
    output logic [INS_ADDR_WIDTH-1:0] imem_addr,
    input  logic [INS_WIDTH-1:0]      imem_dout,
    output logic [INS_WIDTH-1:0]      instruction,
    output logic                      ins_valid,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int DCW = (DRAIN_SLOTS > 1) ? $clog2(DRAIN_SLOTS) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_SLOTS - 1);

    logic [1:0]                state;
    logic                      phase;
    logic [INS_ADDR_WIDTH-1:0] pc;
    logic [DCW-1:0]            drain_cnt;
    logic [1:0]                sb_valid;
    logic [ADDR_WIDTH-1:0]     sb_addr0;
    logic [ADDR_WIDTH-1:0]     sb_addr1;

    logic [OPCODE_WIDTH-1:0]   dec_op;
    logic [ADDR_WIDTH-1:0]     dec_r;
    logic [ADDR_WIDTH-1:0]     dec_a;
    logic [ADDR_WIDTH-1:0]     dec_b;
    logic                      is_halt;
    logic                      hazard;
    logic                      issue;
    logic                      slot_end;
    logic                      drain_last;

    assign dec_op = imem_dout[INS_WIDTH-1 -: OPCODE_WIDTH];
    assign dec_r  = imem_dout[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign dec_a  = imem_dout[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign dec_b  = imem_dout[ADDR_WIDTH-1:0];

    assign is_halt = (dec_op == HALT_OPCODE);

    // Both scoreboard entries hold writes still in flight in the datapath.
    assign hazard = (sb_valid[0] && ((sb_addr0 == dec_a) || (sb_addr0 == dec_b))) ||
                    (sb_valid[1] && ((sb_addr1 == dec_a) || (sb_addr1 == dec_b)));

    assign issue      = (state == S_RUN) && phase && !is_halt && !hazard;
    assign slot_end   = !stall && phase && (state != S_IDLE);
    assign drain_last = (state == S_DRAIN) && (drain_cnt == DRAIN_LAST);

    assign done      = slot_end && drain_last;
    assign busy      = (state != S_IDLE);
    assign imem_addr = pc;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            phase     <= 1'b0;
            pc        <= '0;
            drain_cnt <= '0;
        end else if (!stall) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        pc    <= start_pc;
                        phase <= 1'b0;
                    end
                end
                S_RUN: begin
                    phase <= ~phase;
                    if (phase) begin
                        if (is_halt) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end else if (!hazard) begin
                            pc <= pc + INS_ADDR_WIDTH'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    phase <= ~phase;
                    if (phase) begin
                        if (drain_last) begin
                            state <= S_IDLE;
                        end else begin
                            drain_cnt <= drain_cnt + DCW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // instruction/ins_valid form a valid-only stream: no backpressure other
    // than stall, and each value is held for exactly one full slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            instruction <= '0;
            ins_valid   <= 1'b0;
            sb_valid    <= 2'b00;
            sb_addr0    <= '0;
            sb_addr1    <= '0;
        end else if (!stall && (state == S_IDLE) && start) begin
            sb_valid <= 2'b00;
        end else if (slot_end) begin
            instruction <= issue ? imem_dout : '0;
            ins_valid   <= issue;
            sb_valid    <= {sb_valid[0], issue && (dec_op != '0)};
            sb_addr1    <= sb_addr0;
            sb_addr0    <= dec_r;
        end
    end

endmodule

// File: tb/tb_simd_sequencer.sv
// Self-checking bench for simd_sequencer: slot-level reference trace of the
// program, compared against the DUT outputs on every cycle.
module tb_simd_sequencer;

    localparam int IAW = 8;
    localparam int AW  = 10;
    localparam int OW  = 4;
    localparam int IW  = OW + 3 * AW;
    localparam int DS  = 3;
    localparam logic [3:0] HALT = 4'hF;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           start = 1'b0;
    logic [IAW-1:0] start_pc = '0;
    logic           stall = 1'b0;
    logic [IAW-1:0] imem_addr;
    logic [IW-1:0]  imem_dout;
    logic [IW-1:0]  instruction;
    logic           ins_valid;
    logic           busy;
    logic           done;
    logic [1:0]     dbg_state;

    logic [IW-1:0]  mem [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_dout <= mem[imem_addr];

    simd_sequencer dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .start_pc    (start_pc),
        .stall       (stall),
        .imem_addr   (imem_addr),
        .imem_dout   (imem_dout),
        .instruction (instruction),
        .ins_valid   (ins_valid),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic [3:0] op, input int r, input int a, input int b);
        return {op, AW'(r), AW'(a), AW'(b)};
    endfunction

    // Reference trace: what happens in each slot of the program.
    logic [IAW-1:0] m_pc  [256];
    logic           m_val [256];
    logic [IW-1:0]  m_ins [256];
    logic           m_wv  [256];
    logic [AW-1:0]  m_wr  [256];
    int m_h = 0;
    int m_end = 0;

    task automatic build(input logic [IAW-1:0] spc);
        logic [IAW-1:0] pc;
        logic [IW-1:0]  w;
        logic [AW-1:0]  a, b;
        logic           haz;
        int             h;
        pc = spc;
        h = -1;
        for (int s = 0; s < 256; s++) begin
            w = mem[pc];
            a = w[2*AW-1:AW];
            b = w[AW-1:0];
            m_pc[s] = pc;
            if (w[IW-1 -: 4] == HALT) begin
                h = s;
                break;
            end
            haz = 1'b0;
            for (int d = 1; d <= 2; d++)
                if (s >= d && m_wv[s-d] && (m_wr[s-d] == a || m_wr[s-d] == b)) haz = 1'b1;
            m_val[s] = !haz;
            m_ins[s] = haz ? '0 : w;
            m_wv[s]  = !haz && (w[IW-1 -: 4] != 4'h0);
            m_wr[s]  = w[3*AW-1:2*AW];
            if (!haz) pc = pc + 1'b1;
        end
        check("model_halt_found", 64'(h >= 0), 64'(1));
        m_h = (h >= 0) ? h : 0;
        m_end = 2 * (m_h + DS) + 1;
    endtask

    // t counts non-stalled edges since the accepted start.
    logic           act = 1'b0;
    int             t = 0;
    logic [IAW-1:0] idle_addr = '0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act <= 1'b0;
            t <= 0;
            idle_addr <= '0;
        end else if (!act) begin
            if (start && !stall) begin
                act <= 1'b1;
                t <= 0;
            end
        end else if (!stall) begin
            if (t == m_end) begin
                act <= 1'b0;
                idle_addr <= m_pc[m_h];
            end else begin
                t <= t + 1;
            end
        end
    end

    logic [IW-1:0]  e_ins;
    logic           e_val;
    logic           e_done;
    logic [IAW-1:0] e_addr;
    int             sp;

    always @(negedge clk) begin
        e_ins = '0;
        e_val = 1'b0;
        e_done = 1'b0;
        e_addr = idle_addr;
        if (act) begin
            e_addr = m_pc[((t / 2) <= m_h) ? (t / 2) : m_h];
            if (t >= 2) begin
                sp = (t - 2) / 2;
                if (sp < m_h) begin
                    e_ins = m_ins[sp];
                    e_val = m_val[sp];
                end
            end
            e_done = (t == m_end) && !stall;
        end
        check("busy", 64'(busy), 64'(act));
        check("done", 64'(done), 64'(e_done));
        check("ins_valid", 64'(ins_valid), 64'(e_val));
        check("instruction", 64'(instruction), 64'(e_ins));
        check("imem_addr", 64'(imem_addr), 64'(e_addr));
    end

    task automatic do_start(input logic [IAW-1:0] spc);
        @(posedge clk); #1;
        start = 1'b1;
        start_pc = spc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // n is the cycle (1 = first cycle after the start edge) in which done was seen.
    task automatic run_prog(input logic [IAW-1:0] spc, input bit rnd, input int stall_at,
                            input bit poke, output int n);
        bit got;
        got = 1'b0;
        n = 0;
        build(spc);
        do_start(spc);
        while (!got && n < 3000) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) got = 1'b1;
            @(posedge clk); #1;
            stall = !got && ((stall_at >= 0 && n >= stall_at && n < stall_at + 5) ||
                             (rnd && $urandom_range(0, 3) == 0));
            start = poke && (n == 5);
            if (poke && n == 5) start_pc = 8'h00;
        end
        stall = 1'b0;
        start = 1'b0;
        if (!got) check("done_timeout", 64'(0), 64'(1));
        repeat (3) @(posedge clk);
        #1;
    endtask

    int n;
    int nvalid;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ins_valid", 64'(ins_valid), 64'(0));
        check("rst_instruction", 64'(instruction), 64'(0));
        check("rst_imem_addr", 64'(imem_addr), 64'(0));

        // Straight-line, with a start pulse while busy.
        for (int i = 0; i < 4; i++) mem[8'h10 + i] = mk(4'h1, 10 + i, 20 + i, 30 + i);
        mem[8'h14] = mk(HALT, 0, 0, 0);
        run_prog(8'h10, 1'b0, -1, 1'b1, n);
        check("straight_halt_slot", 64'(m_h), 64'(4));
        check("straight_pc3", 64'(m_pc[3]), 64'(8'h13));
        check("straight_halt_pc", 64'(m_pc[4]), 64'(8'h14));
        check("straight_done_cycle", 64'(n), 64'(16));

        // Back-to-back RAW.
        mem[8'h20] = mk(4'h1, 5, 1, 2);
        mem[8'h21] = mk(4'h2, 9, 5, 3);
        mem[8'h22] = mk(HALT, 0, 0, 0);
        run_prog(8'h20, 1'b0, -1, 1'b0, n);
        check("raw1_bubble1", 64'(m_val[1]), 64'(0));
        check("raw1_bubble2", 64'(m_val[2]), 64'(0));
        check("raw1_issue", 64'(m_val[3]), 64'(1));
        check("raw1_done_cycle", 64'(n), 64'(16));

        // RAW at distance 2.
        mem[8'h30] = mk(4'h1, 5, 1, 2);
        mem[8'h31] = mk(4'h1, 6, 1, 2);
        mem[8'h32] = mk(4'h2, 9, 5, 3);
        mem[8'h33] = mk(HALT, 0, 0, 0);
        run_prog(8'h30, 1'b0, -1, 1'b0, n);
        check("raw2_bubble", 64'(m_val[2]), 64'(0));
        check("raw2_halt_slot", 64'(m_h), 64'(4));
        check("raw2_done_cycle", 64'(n), 64'(16));

        // No false hazards, including a NOP naming r=5.
        mem[8'h40] = mk(4'h1, 5, 1, 2);
        mem[8'h41] = mk(4'h2, 8, 6, 7);
        mem[8'h42] = mk(4'h0, 5, 0, 0);
        mem[8'h43] = mk(4'h3, 9, 5, 1);
        mem[8'h44] = mk(HALT, 0, 0, 0);
        run_prog(8'h40, 1'b0, -1, 1'b0, n);
        nvalid = 0;
        for (int i = 0; i < 4; i++) nvalid += int'(m_val[i]);
        check("nofalse_issues", 64'(nvalid), 64'(4));
        check("nofalse_done_cycle", 64'(n), 64'(16));

        // Five-cycle stall mid-slot delays everything by five.
        run_prog(8'h10, 1'b0, 3, 1'b0, n);
        check("stall_done_cycle", 64'(n), 64'(21));

        // pc wrap.
        mem[8'hFF] = mk(4'h1, 1, 2, 3);
        mem[8'h00] = mk(HALT, 0, 0, 0);
        run_prog(8'hFF, 1'b0, -1, 1'b0, n);
        check("wrap_halt_pc", 64'(m_pc[1]), 64'(0));
        check("wrap_done_cycle", 64'(n), 64'(10));

        // Asynchronous reset mid-run, then a clean restart.
        build(8'h10);
        do_start(8'h10);
        repeat (4) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_ins_valid", 64'(ins_valid), 64'(0));
        check("midrst_instruction", 64'(instruction), 64'(0));
        check("midrst_imem_addr", 64'(imem_addr), 64'(0));
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        run_prog(8'h10, 1'b0, -1, 1'b0, n);
        check("restart_done_cycle", 64'(n), 64'(16));

        // Random programs with dense register reuse and random stalls.
        for (int k = 0; k < 10; k++) begin
            logic [IAW-1:0] spc;
            int len;
            spc = IAW'($urandom_range(0, 255));
            len = $urandom_range(3, 20);
            for (int i = 0; i < len; i++)
                mem[spc + IAW'(i)] = mk(4'($urandom_range(0, 14)), $urandom_range(0, 3),
                                        $urandom_range(0, 3), $urandom_range(0, 3));
            mem[spc + IAW'(len)] = mk(HALT, 0, 0, 0);
            run_prog(spc, 1'b1, -1, (k % 3) == 0, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
